pipeline_inst_pipe: RTL

Instruction pipe register array for the 4-stage CPU. It owns stages 1–4, from Fetch through RegFile Write. It accepts fetched instructions and shifts them down the pipe, and presents `inst_ipipe[1:4]` and `opcode[1:4]` to the control decoder and the hazard checker. It applies stalls from the hazard checker by holding stages 1–2 and injecting a bubble into stage 3. It applies flushes from branch resolution by killing younger instructions.

---
 rtl/pipeline_inst_pipe.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pipeline_inst_pipe.sv
// pipeline_inst_pipe
// Instruction pipe register array for the 4-stage CPU (Fetch .. RegFile Write).
// Stage 1 is the youngest instruction and stage 4 the oldest.
//
// Per-edge priority: reset, flush, stall, advance.
//   advance : s4<-s3, s3<-s2, s2<-s1, s1<-fetch (bubble when fetch_valid=0)
//   stall   : s4<-s3, s3<-bubble, s2/s1 hold
//   flush   : s4<-s3, s3/s2/s1<-bubble
//
// Every bubble word is exactly BUBBLE_INST, so the decoder can use opcode[]
// without qualifying it by valid[].
//
// Optional feature macro: PIPE_PERF_CNT_EN
//   When defined, adds saturating stall_cnt / flush_cnt performance counters
//   of width CNT_W. When undefined, the ports and their logic are absent.

module pipeline_inst_pipe #(
    parameter logic [15:0] BUBBLE_INST = 16'h0007,
    parameter int          CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       fetch_inst,
    input  logic              fetch_valid,
    output logic              fetch_ready,
    input  logic              stall,
    input  logic              flush,
    output logic [15:0]       inst_ipipe [1:4],
    output logic [4:0]        opcode     [1:4],
`ifdef PIPE_PERF_CNT_EN
    output logic [4:1]        valid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`else
    output logic [4:1]        valid
`endif
);

    logic [15:0] inst_q [1:4];
    logic [15:0] inst_d [1:4];
    logic [4:1]  valid_q;
    logic [4:1]  valid_d;

    // Qualified control: flush dominates stall; advance only when neither is set.
    logic do_flush;
    logic do_stall;
    logic do_advance;

    // Decode the per-edge action from the hazard and branch inputs.
    always_comb begin
        do_flush   = flush;
        do_stall   = stall & ~flush;
        do_advance = ~stall & ~flush;
    end

    // Fetch consumes the word only in an advancing cycle.
    assign fetch_ready = do_advance;

    // Next-state for the four stage registers; the valid bit always moves with its word.
    always_comb begin
        for (int i = 1; i <= 4; i++) begin
            inst_d[i] = inst_q[i];
        end
        valid_d = valid_q;

        // Stage 4 always receives stage 3, so the resolving branch retires on a flush.
        inst_d[4]  = inst_q[3];
        valid_d[4] = valid_q[3];

        if (do_flush) begin
            for (int i = 1; i <= 3; i++) begin
                inst_d[i]  = BUBBLE_INST;
                valid_d[i] = 1'b0;
            end
        end else if (do_stall) begin
            inst_d[3]  = BUBBLE_INST;
            valid_d[3] = 1'b0;
        end else begin
            inst_d[3]  = inst_q[2];
            valid_d[3] = valid_q[2];
            inst_d[2]  = inst_q[1];
            valid_d[2] = valid_q[1];
            if (fetch_valid) begin
                inst_d[1]  = fetch_inst;
                valid_d[1] = 1'b1;
            end else begin
                inst_d[1]  = BUBBLE_INST;
                valid_d[1] = 1'b0;
            end
        end
    end

    // Stage registers; asynchronous reset fills the pipe with bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i <= 4; i++) begin
                inst_q[i] <= BUBBLE_INST;
            end
            valid_q <= '0;
        end else begin
            for (int i = 1; i <= 4; i++) begin
                inst_q[i] <= inst_d[i];
            end
            valid_q <= valid_d;
        end
    end

    // Opcode is a plain slice of each registered word, no extra flop.
    always_comb begin
        for (int i = 1; i <= 4; i++) begin
            inst_ipipe[i] = inst_q[i];
            opcode[i]     = inst_q[i][4:0];
        end
        valid = valid_q;
    end

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    // Saturating event counters; a flush cycle is not counted as a stall.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (do_stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (do_flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
